alu_issue: RTL and testbench
============================

# alu_issue

Sequential issue/writeback stage that sits directly upstream of the combinational `alu` and feeds it. It holds a small register file and accepts register-addressed instructions over a valid/ready handshake. For each instruction it reads two operands, drives `alu` (`a`, `b`, `alu_op`, `result`), writes the result back to the register file and presents it on a valid/ready output stream. A host port preloads constants, and a debug port reads any register.

## Interface
- `NREG`, default 16: number of 32-bit registers; must be a power of two. `AW = $clog2(NREG)`.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — instruction valid.
- `in_ready`  out  1  — instruction accepted when `in_valid & in_ready` at a rising edge.
- `in_op`  in  4  — ALU opcode, passed unchanged to `alu_op`.
- `in_rd`, `in_rs1`, `in_rs2`  in  AW each  — destination, operand-a source, operand-b source.
- `host_we`  in  1  — host register write strobe.
- `host_addr`  in  AW  — host write address.
- `host_wdata`  in  32  — host write data.
- `dbg_raddr`  in  AW  — debug read address.
- `dbg_rdata`  out  32  — combinational read of the addressed register.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — result consumed when `out_valid & out_ready` at a rising edge.
- `out_rd`  out  AW  — destination of the presented result.
- `out_result`  out  32  — result written to `out_rd`.
- `busy`  out  1  — high whenever the state is not IDLE.
- `err_illegal`  out  1  — sticky flag: an opcode in 4'b1001..4'b1111 was executed.

## Operation
- **Legal opcodes** (handled by `alu`): 0000 ADD, 0001 SUB, 0010 MUL (low 32 bits), 0011 SHL, 0100 SHR, 0101 FMUL, 0110 FLOOR, 0111 FLOOR_TO_INT, 1000 FCMP.
- **Illegal opcodes:** `alu` returns 0. That 0 is written back and presented like any other result. `err_illegal` is set and stays set until reset.
- **IDLE:** `in_ready = 1`. On handshake, capture `op`, `rd`, `rs1`, `rs2` into instruction registers; go to READ.
- **READ:** latch `a_q <= rf[rs1]` and `b_q <= rf[rs2]` (values before this edge's write); go to EXEC.
- **EXEC:** `alu` sees `a_q`, `b_q`, `op_q`. At the edge:
  - `res_q <= result`;
  - `rf[rd_q] <= result`, unless a host write to the same address happens on the same edge (host wins);
  - go to WB.
- **WB:** `out_valid = 1`; `out_rd = rd_q`; `out_result = res_q`. Hold until `out_ready`, then go to IDLE.
- **Host writes:** `host_we` writes `rf[host_addr]` on any edge in any state.
  - A host write during READ to a source register is not seen by the operand latch; the old value is used.
- **`dbg_rdata`:** combinational `rf[dbg_raddr]`. It shows a writeback on the cycle after the EXEC edge.
- **Aliasing:** `rd == rs1 == rs2` is legal, because operands are latched before writeback.
- **Reset (asynchronous, any state):**
  - All `rf` entries, `a_q`, `b_q`, `res_q` and the instruction registers go to 0; state goes to IDLE; `err_illegal` goes to 0.
  - An instruction in flight is dropped with no writeback and no `out_valid`.
  - `in_ready` is forced to 0 while `rst` is high.

## Timing
- **Reset values:**
  - `in_ready` is 0 during reset and 1 on the first cycle after release.
  - `out_valid`, `out_rd`, `out_result`, `busy` and `err_illegal` are 0.
  - `dbg_rdata` is 0 for every address.
- **Latency:** instruction accepted at edge E0, then READ at E1 and EXEC at E2. `out_valid` rises in the cycle after E2 (3 cycles after acceptance), and the register file is updated at E2.
- **Throughput:** 4 cycles per instruction with `out_ready` held high. With `out_ready` low, the block stalls in WB indefinitely.
- **`in_ready`:** combinational from state (`state == IDLE && !rst`), with no dependence on `in_valid`.
- **`out_valid` stability:** once high, `out_valid`, `out_rd` and `out_result` stay stable until the handshake. `out_valid` never drops without a handshake except on reset.
- **`busy`:** equals `!(state == IDLE)`.

## Test plan
- **ADD:** host writes r1=10, r2=20; issue ADD rd=3 rs1=1 rs2=2 → `out_valid` exactly 3 cycles after acceptance, `out_rd=3`, `out_result=30`; `dbg_raddr=3` reads 30.
- **FMUL:** r4=0x40200000, r5=0x40800000; issue op 0101 rd=6 → `out_result=0x41200000` (10.0).
- **Back-to-back with backpressure:** issue ADD r3=r1+r2, then SHL r7=r3<<r8 (r8=2), holding `out_ready` low for 5 cycles on the first result.
  - During the stall: `out_valid`, `out_result=30` and `in_ready=0` stay stable.
  - After release: the second result is `out_result=120`, `out_rd=7`.
- **Illegal opcode:** r9=0xFFFFFFFF; issue op 1111 rd=9 rs1=1 rs2=2 → `out_result=0`, r9 reads 0, `err_illegal=1`. A following legal ADD leaves `err_illegal=1`.
- **Writeback collision:** `host_we` to rd=3 with data 0xDEADBEEF on the EXEC edge of ADD rd=3 → `out_result=30`, but r3 reads 0xDEADBEEF.
- **Reset mid-operation:** assert `rst` asynchronously during EXEC → `out_valid` never rises; r1, r2 and r3 read 0; after release `in_ready=1` and `busy=0`.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage wrapped around a combinational ALU.
// Accepts register-addressed instructions over in_valid/in_ready. Each one is
// handled in four steps: capture, operand read, execute with writeback, and
// result hold. The result is presented on out_valid/out_ready.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready           instruction handshake
//   in_op, in_rd, in_rs1, in_rs2  opcode and register addresses
//   host_we/host_addr/host_wdata  host register write (host wins collisions)
//   dbg_raddr/dbg_rdata         combinational register read
//   out_valid/out_ready         result handshake
//   out_rd, out_result          presented destination and result
//   busy                        state is not IDLE
//   err_illegal                 sticky: opcode 1001..1111 was executed
module alu_issue #(
  parameter int unsigned NREG = 16,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic [AW-1:0] dbg_raddr,
  output logic [31:0]   dbg_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_rd,
  output logic [31:0]   out_result,
  output logic          busy,
  output logic          err_illegal
);

  localparam int unsigned DW = 32;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_SHL   = 4'd3;
  localparam logic [3:0] OP_SHR   = 4'd4;
  localparam logic [3:0] OP_FMUL  = 4'd5;
  localparam logic [3:0] OP_FLOOR = 4'd6;
  localparam logic [3:0] OP_FTOI  = 4'd7;
  localparam logic [3:0] OP_FCMP  = 4'd8;
  localparam logic [DW-1:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DW-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic             err_q, err_d;
  logic [DW-1:0]    rf_q [NREG];
  logic [DW-1:0]    rf_d [NREG];
  logic [DW-1:0]    alu_result_c;

  // Float field decode (denormals are treated as zero)
  logic [7:0] a_e, b_e;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_e    = a_q[30:23];
  assign b_e    = b_q[30:23];
  assign a_nan  = (a_e == 8'hFF) && (a_q[22:0] != '0);
  assign b_nan  = (b_e == 8'hFF) && (b_q[22:0] != '0);
  assign a_inf  = (a_e == 8'hFF) && (a_q[22:0] == '0);
  assign b_inf  = (b_e == 8'hFF) && (b_q[22:0] == '0);
  assign a_zero = (a_e == 8'h00);
  assign b_zero = (b_e == 8'h00);

  // FMUL: normalise the 48-bit product, round to nearest even; carry ripples into exponent
  logic [47:0] fm_p;
  logic [46:0] fm_n;
  logic [9:0]  fm_e;
  logic        fm_up;
  logic [32:0] fm_r;
  assign fm_p  = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
  assign fm_n  = fm_p[47] ? fm_p[46:0] : {fm_p[45:0], 1'b0};
  assign fm_e  = 10'(a_e) + 10'(b_e) + 10'(fm_p[47]) - 10'd127;
  assign fm_up = fm_n[23] & ((|fm_n[22:0]) | fm_n[24]);
  assign fm_r  = {fm_e, fm_n[46:24]} + 33'(fm_up);

  // FLOOR: clear fraction bits; negative values with a fraction step one unit down
  logic [7:0]    fl_fb;
  logic [DW-1:0] fl_mask, fl_trunc;
  assign fl_fb    = 8'd150 - a_e;
  assign fl_mask  = (32'd1 << fl_fb) - 32'd1;
  assign fl_trunc = a_q & ~fl_mask;

  // FLOOR_TO_INT: integer part in [54:23], fraction in [22:0]
  logic [54:0]   ti_wide;
  logic [DW-1:0] ti_mag;
  logic          ti_frac;
  assign ti_wide = 55'({1'b1, a_q[22:0]}) << (a_e - 8'd127);
  assign ti_mag  = ti_wide[54:23];
  assign ti_frac = |ti_wide[22:0];

  // FCMP: sign-magnitude mapped to an unsigned total order
  logic [DW-1:0] ka, kb;
  logic          both_zero;
  assign ka        = a_q[31] ? ~a_q : {1'b1, a_q[30:0]};
  assign kb        = b_q[31] ? ~b_q : {1'b1, b_q[30:0]};
  assign both_zero = (a_q[30:0] == '0) && (b_q[30:0] == '0);

  // ALU: FCMP gives -1 (a<b), 1 (a>b), 0 (equal or unordered); illegal ops give 0
  always_comb begin
    alu_result_c = '0;
    case (op_q)
      OP_ADD: alu_result_c = a_q + b_q;
      OP_SUB: alu_result_c = a_q - b_q;
      OP_MUL: alu_result_c = a_q * b_q;
      OP_SHL: alu_result_c = a_q << b_q[4:0];
      OP_SHR: alu_result_c = a_q >> b_q[4:0];
      OP_FMUL: begin
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) alu_result_c = QNAN;
        else if (a_inf || b_inf)               alu_result_c = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
        else if (a_zero || b_zero)             alu_result_c = {a_q[31] ^ b_q[31], 31'd0};
        else if (fm_e[9] || fm_e == 10'd0)     alu_result_c = {a_q[31] ^ b_q[31], 31'd0};
        else if (fm_r[32:23] >= 10'd255)       alu_result_c = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
        else                                   alu_result_c = {a_q[31] ^ b_q[31], fm_r[30:0]};
      end
      OP_FLOOR: begin
        if (a_nan || a_e >= 8'd150)                      alu_result_c = a_q;
        else if (a_e < 8'd127)                           alu_result_c = (a_q[31] && a_q[30:0] != '0) ?
                                                                        32'hBF80_0000 : {a_q[31], 31'd0};
        else if (a_q[31] && (a_q & fl_mask) != '0)       alu_result_c = fl_trunc + fl_mask + 32'd1;
        else                                             alu_result_c = fl_trunc;
      end
      OP_FTOI: begin
        if (a_nan)                  alu_result_c = '0;
        else if (a_e < 8'd127)      alu_result_c = (a_q[31] && a_q[30:0] != '0) ? 32'hFFFF_FFFF : 32'd0;
        else if (a_e >= 8'd158)     alu_result_c = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (a_q[31])           alu_result_c = 32'd0 - (ti_mag + 32'(ti_frac));
        else                        alu_result_c = ti_mag;
      end
      OP_FCMP: begin
        if (a_nan || b_nan || both_zero) alu_result_c = '0;
        else if (ka < kb)                alu_result_c = 32'hFFFF_FFFF;
        else if (ka > kb)                alu_result_c = 32'd1;
        else                             alu_result_c = '0;
      end
      default: alu_result_c = '0;
    endcase
  end

  // Next state and datapath; the host write is applied last so it wins over writeback
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    rf_d    = rf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = rf_q[rs1_q];
        b_d     = rf_q[rs2_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d      = alu_result_c;
        rf_d[rd_q] = alu_result_c;
        if (op_q > OP_FCMP) err_d = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (host_we) rf_d[host_addr] = host_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      rf_q    <= rf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_WB);
  assign out_rd      = rd_q;
  assign out_result  = res_q;
  assign err_illegal = err_q;
  assign dbg_rdata   = rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios, a table of ALU
// vectors, and randomized integer/illegal instructions against a register model.
module tb_alu_issue;
  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [AW-1:0] dbg_raddr;
  logic [31:0]   dbg_rdata;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_rd;
  logic [31:0]   out_result;
  logic          busy, err_illegal;

  always #5 clk = ~clk;

  alu_issue #(.NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result),
    .busy(busy), .err_illegal(err_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_rf [NREG];
  logic        m_err;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Integer reference: plain arithmetic, shift distance modulo 32, illegal -> 0
  function automatic logic [31:0] ref_int(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a << (b % 32);
      4'd4:    return a >> (b % 32);
      default: return 32'd0;
    endcase
  endfunction

  task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic send(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  // Issue, check latency/stall stability/result/writeback/error flag, then consume
  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [31:0] exp, input int stall,
                        input string name);
    int lat;
    out_ready = (stall == 0);
    send(op, rd, rs1, rs2);
    wait_out(lat);
    chk({name, "_latency"}, 32'(lat), 32'd3);
    m_rf[rd] = exp;
    if (op > 4'd8) m_err = 1'b1;
    dbg_raddr = rd;
    #1;
    chk({name, "_dbg"}, dbg_rdata, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_stall_result"}, out_result, exp);
      chk({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    chk({name, "_result"}, out_result, exp);
    chk({name, "_rd"}, 32'(out_rd), 32'(rd));
    chk({name, "_err"}, 32'(err_illegal), 32'(m_err));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [3:0] op;
    logic [AW-1:0] rd, rs1, rs2;
    int k;

    tbl[0]  = '{4'd0, 32'd10,         32'd20,         32'd30};
    tbl[1]  = '{4'd1, 32'd5,          32'd7,          32'hFFFF_FFFE};
    tbl[2]  = '{4'd2, 32'd7,          32'd6,          32'd42};
    tbl[3]  = '{4'd2, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000};
    tbl[4]  = '{4'd3, 32'd30,         32'd2,          32'd120};
    tbl[5]  = '{4'd4, 32'h8000_0000,  32'd31,         32'd1};
    tbl[6]  = '{4'd5, 32'h4020_0000,  32'h4080_0000,  32'h4120_0000};
    tbl[7]  = '{4'd5, 32'hBF80_0000,  32'h4000_0000,  32'hC000_0000};
    tbl[8]  = '{4'd6, 32'hBFC0_0000,  32'd0,          32'hC000_0000};
    tbl[9]  = '{4'd6, 32'h4070_0000,  32'd0,          32'h4040_0000};
    tbl[10] = '{4'd7, 32'hBFC0_0000,  32'd0,          32'hFFFF_FFFE};
    tbl[11] = '{4'd7, 32'h4070_0000,  32'd0,          32'd3};
    tbl[12] = '{4'd8, 32'h3F80_0000,  32'h4000_0000,  32'hFFFF_FFFF};
    tbl[13] = '{4'd9, 32'd123,        32'd456,        32'd0};

    for (int i = 0; i < int'(NREG); i++) m_rf[i] = '0;
    m_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; dbg_raddr = '0; out_ready = 1'b1;

    // Reset values
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(NREG); i++) begin
      dbg_raddr = AW'(i);
      #1;
      chk($sformatf("rst_rf%0d", i), dbg_rdata, 32'd0);
    end

    // ADD and FMUL
    host_wr(4'd1, 32'd10);
    host_wr(4'd2, 32'd20);
    run_op(4'd0, 4'd3, 4'd1, 4'd2, 32'd30, 0, "add");
    host_wr(4'd4, 32'h4020_0000);
    host_wr(4'd5, 32'h4080_0000);
    run_op(4'd5, 4'd6, 4'd4, 4'd5, 32'h4120_0000, 0, "fmul");

    // Back-to-back with 5 cycles of backpressure on the first result
    host_wr(4'd8, 32'd2);
    run_op(4'd0, 4'd3, 4'd1, 4'd2, 32'd30, 5, "bp_add");
    run_op(4'd3, 4'd7, 4'd3, 4'd8, 32'd120, 0, "bp_shl");

    // Aliasing rd == rs1 == rs2
    host_wr(4'd4, 32'd7);
    run_op(4'd0, 4'd4, 4'd4, 4'd4, 32'd14, 0, "alias");

    // Host write on the EXEC edge to the destination: host wins
    out_ready = 1'b1;
    send(4'd0, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    host_we = 1'b1; host_addr = 4'd3; host_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    host_we = 1'b0;
    dbg_raddr = 4'd3;
    #1;
    chk("coll_valid", 32'(out_valid), 32'd1);
    chk("coll_result", out_result, 32'd30);
    chk("coll_rf3", dbg_rdata, 32'hDEAD_BEEF);
    m_rf[3] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // Host write during READ to a source: operand latch uses the old value
    send(4'd0, 4'd11, 4'd1, 4'd2);
    @(negedge clk);
    host_we = 1'b1; host_addr = 4'd1; host_wdata = 32'd100;
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    dbg_raddr = 4'd1;
    #1;
    chk("rdhaz_valid", 32'(out_valid), 32'd1);
    chk("rdhaz_result", out_result, 32'd30);
    chk("rdhaz_rf1", dbg_rdata, 32'd100);
    m_rf[1] = 32'd100;
    m_rf[11] = 32'd30;
    @(posedge clk);
    #1;

    // Illegal opcode: result 0 written back, sticky error
    host_wr(4'd9, 32'hFFFF_FFFF);
    chk("err_before_illegal", 32'(err_illegal), 32'd0);
    run_op(4'hF, 4'd9, 4'd1, 4'd2, 32'd0, 0, "illegal");
    run_op(4'd0, 4'd12, 4'd1, 4'd2, m_rf[1] + m_rf[2], 0, "after_illegal");

    // Table of ALU vectors through r1/r2 into r10
    for (int i = 0; i < 14; i++) begin
      host_wr(4'd1, tbl[i].a);
      host_wr(4'd2, tbl[i].b);
      run_op(tbl[i].op, 4'd10, 4'd1, 4'd2, tbl[i].exp, 0, $sformatf("vec%0d", i));
    end

    // Randomized integer and illegal instructions with random stalls
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) host_wr(AW'($urandom_range(0, 15)), $urandom);
      k   = $urandom_range(0, 5);
      op  = (k < 5) ? 4'(k) : 4'($urandom_range(9, 15));
      rd  = AW'($urandom_range(0, 15));
      rs1 = AW'($urandom_range(0, 15));
      rs2 = AW'($urandom_range(0, 15));
      run_op(op, rd, rs1, rs2, ref_int(op, m_rf[rs1], m_rf[rs2]), $urandom_range(0, 3),
             $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < int'(NREG); i++) begin
      dbg_raddr = AW'(i);
      #1;
      chk($sformatf("rnd_rf%0d", i), dbg_rdata, m_rf[i]);
    end

    // Asynchronous reset during EXEC drops the instruction
    out_ready = 1'b1;
    send(4'd0, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_err", 32'(err_illegal), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
    end
    for (int i = 1; i <= 3; i++) begin
      dbg_raddr = AW'(i);
      #1;
      chk($sformatf("midrst_rf%0d", i), dbg_rdata, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_rel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < int'(NREG); i++) m_rf[i] = '0;
    m_err = 1'b0;
    wait_out(lat);
    chk("midrst_no_valid", 32'(out_valid), 32'd0);
    host_wr(4'd1, 32'd1);
    host_wr(4'd2, 32'd2);
    run_op(4'd0, 4'd3, 4'd1, 4'd2, 32'd3, 0, "post_rst_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
